// File: rtl/ctrl_pkg.sv
// Shared constants and types for the SAP controller-sequencer: opcodes, micro-step
// numbers and the packed control word in hlt..j order.
package ctrl_pkg;

    typedef logic [2:0] step_t;
    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_NOP = 4'h0;
    localparam opcode_t OP_LDA = 4'h1;
    localparam opcode_t OP_ADD = 4'h2;
    localparam opcode_t OP_SUB = 4'h3;
    localparam opcode_t OP_STA = 4'h4;
    localparam opcode_t OP_LDI = 4'h5;
    localparam opcode_t OP_JMP = 4'h6;
    localparam opcode_t OP_JC  = 4'h7;
    localparam opcode_t OP_JZ  = 4'h8;
    localparam opcode_t OP_OUT = 4'hE;
    localparam opcode_t OP_HLT = 4'hF;

    localparam step_t T0 = 3'd0;
    localparam step_t T1 = 3'd1;
    localparam step_t T2 = 3'd2;
    localparam step_t T3 = 3'd3;
    localparam step_t T4 = 3'd4;
    localparam step_t LAST_STEP = T4;

    typedef struct packed {
        logic hlt;
        logic mi;
        logic ri;
        logic ro;
        logic ii;
        logic io;
        logic ai;
        logic ao;
        logic bi;
        logic eo;
        logic su;
        logic fi;
        logic oi;
        logic ce;
        logic co;
        logic j;
    } ctrl_word_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle between the sequencer and the SAP datapath: instruction/flag inputs,
// the control word strobes and the debug step count.
interface control_sequencer_if;
    import ctrl_pkg::*;

    logic    prog_mode;
    opcode_t opcode;
    logic    carry_flag;
    logic    zero_flag;
    logic    hlt, mi, ri, ro, ii, io, ai, ao, bi, eo, su, fi, oi, ce, co, j;
    step_t   step;

    modport master (
        input  prog_mode, opcode, carry_flag, zero_flag,
        output hlt, mi, ri, ro, ii, io, ai, ao, bi, eo, su, fi, oi, ce, co, j, step
    );

    modport slave (
        output prog_mode, opcode, carry_flag, zero_flag,
        input  hlt, mi, ri, ro, ii, io, ai, ao, bi, eo, su, fi, oi, ce, co, j, step
    );

endinterface

// File: rtl/ctrl_microcode.sv
// Combinational microcode ROM: (step, opcode, flags) -> control word + last_step.
// CTRL_COND_JUMP_EN enables JC/JZ; otherwise they decode as NOP and flags are ignored.
module ctrl_microcode
    import ctrl_pkg::*;
(
    input  step_t      step,
    input  opcode_t    opcode,
    input  logic       carry_flag,
    input  logic       zero_flag,
    output ctrl_word_t cw,
    output logic       last_step
);

`ifndef CTRL_COND_JUMP_EN
    logic unused_flags;
    assign unused_flags = carry_flag | zero_flag;
`endif

    always_comb begin
        cw        = '0;
        last_step = 1'b0;
        case (step)
            T0: begin
                cw.co = 1'b1;
                cw.mi = 1'b1;
            end
            T1: begin
                cw.ro = 1'b1;
                cw.ii = 1'b1;
                cw.ce = 1'b1;
            end
            T2: begin
                // T2 is the earliest possible end; multi-step ops clear the flag
                last_step = 1'b1;
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        cw.io     = 1'b1;
                        cw.mi     = 1'b1;
                        last_step = 1'b0;
                    end
                    OP_LDI: begin
                        cw.io = 1'b1;
                        cw.ai = 1'b1;
                    end
                    OP_JMP: begin
                        cw.io = 1'b1;
                        cw.j  = 1'b1;
                    end
`ifdef CTRL_COND_JUMP_EN
                    OP_JC: begin
                        cw.io = carry_flag;
                        cw.j  = carry_flag;
                    end
                    OP_JZ: begin
                        cw.io = zero_flag;
                        cw.j  = zero_flag;
                    end
`else
                    OP_JC, OP_JZ: ;
`endif
                    OP_OUT: begin
                        cw.ao = 1'b1;
                        cw.oi = 1'b1;
                    end
                    OP_HLT: cw.hlt = 1'b1;
                    OP_NOP: ;
                    default: ;
                endcase
            end
            T3: begin
                last_step = 1'b1;
                case (opcode)
                    OP_LDA: begin
                        cw.ro = 1'b1;
                        cw.ai = 1'b1;
                    end
                    OP_STA: begin
                        cw.ao = 1'b1;
                        cw.ri = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        cw.ro     = 1'b1;
                        cw.bi     = 1'b1;
                        last_step = 1'b0;
                    end
                    default: ;
                endcase
            end
            T4: begin
                last_step = 1'b1;
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    cw.eo = 1'b1;
                    cw.ai = 1'b1;
                    cw.fi = 1'b1;
                    cw.su = (opcode == OP_SUB);
                end
            end
            default: last_step = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// SAP controller-sequencer top: step counter, halted latch and output gating
// around ctrl_microcode. Conditional jumps depend on CTRL_COND_JUMP_EN.
module control_sequencer
    import ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                clear,
    control_sequencer_if.master bus
);

    step_t      step_q;
    logic       halted;
    logic       last_step;
    ctrl_word_t decoded;
    ctrl_word_t driven;

    ctrl_microcode u_microcode (
        .step       (step_q),
        .opcode     (bus.opcode),
        .carry_flag (bus.carry_flag),
        .zero_flag  (bus.zero_flag),
        .cw         (decoded),
        .last_step  (last_step)
    );

    // Priority: clear > prog_mode > halted > halt entry > normal stepping
    always_ff @(posedge clk) begin
        if (clear) begin
            step_q <= T0;
            halted <= 1'b0;
        end else if (bus.prog_mode) begin
            step_q <= T0;
        end else if (halted) begin
            step_q <= step_q;
        end else if (decoded.hlt) begin
            halted <= 1'b1;
        end else if (last_step || step_q >= LAST_STEP) begin
            step_q <= T0;
        end else begin
            step_q <= step_q + 3'd1;
        end
    end

    // hlt survives prog_mode while halted, but nothing survives clear
    always_comb begin
        driven = '0;
        if (!(clear || bus.prog_mode || halted)) begin
            driven = decoded;
        end
        driven.hlt = ~clear & (halted | (decoded.hlt & ~bus.prog_mode));
    end

    assign bus.hlt  = driven.hlt;
    assign bus.mi   = driven.mi;
    assign bus.ri   = driven.ri;
    assign bus.ro   = driven.ro;
    assign bus.ii   = driven.ii;
    assign bus.io   = driven.io;
    assign bus.ai   = driven.ai;
    assign bus.ao   = driven.ao;
    assign bus.bi   = driven.bi;
    assign bus.eo   = driven.eo;
    assign bus.su   = driven.su;
    assign bus.fi   = driven.fi;
    assign bus.oi   = driven.oi;
    assign bus.ce   = driven.ce;
    assign bus.co   = driven.co;
    assign bus.j    = driven.j;
    assign bus.step = clear ? T0 : step_q;

endmodule
